fully_pipelined_adder: RTL and testbench

Parameterised `WIDTH`-bit adder with carry-in, pipelined one bit per stage so a new operand set can be accepted every clock. Stage *i* computes sum bit *i* from the carry registered by stage *i-1*. Higher operand bits are delayed through skew registers and lower sum bits through deskew registers, so each result emerges aligned. It is a throughput-oriented arithmetic leaf for datapaths where a long ripple-carry chain would limit clock frequency.

---
 rtl/fully_pipelined_adder.sv | 118 +++++++++++
 tb/tb_fully_pipelined_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fully_pipelined_adder.sv
// Bit-serial-in-space adder: one sum bit per pipeline stage, operands skewed in and sums deskewed out.
// Define FPA_OUTPUT_REG_EN to add one more enabled/resettable register on s and carry.
module fully_pipelined_adder #(
  parameter int WIDTH = 8
) (
  output logic [WIDTH-1:0] s,
  output logic             carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             en,
  input  logic             clk,
  input  logic             rst
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : stage
    logic          a_in;
    logic          b_in;
    logic          c_in;
    logic          sum_bit;
    logic          cout;
    logic [gi:0]   sum_d;
    logic [gi:0]   sum_q;
    logic          carry_d;
    logic          carry_q;

    if (gi == 0) begin : g_src
      assign a_in = a[0];
      assign b_in = b[0];
      assign c_in = c;
      always_comb sum_d = en ? sum_bit : sum_q;
    end else begin : g_src
      // Operand bit gi sits at index 0 of the previous stage's skew register
      assign a_in = stage[gi-1].g_skew.a_q[0];
      assign b_in = stage[gi-1].g_skew.b_q[0];
      assign c_in = stage[gi-1].carry_q;
      always_comb sum_d = en ? {sum_bit, stage[gi-1].sum_q} : sum_q;
    end

    assign sum_bit = a_in ^ b_in ^ c_in;
    assign cout    = (a_in & b_in) | (c_in & (a_in ^ b_in));

    always_comb carry_d = en ? cout : carry_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    // Operand bits gi+1..WIDTH-1 still waiting for their stage
    if (gi < WIDTH-1) begin : g_skew
      logic [WIDTH-2-gi:0] a_d;
      logic [WIDTH-2-gi:0] a_q;
      logic [WIDTH-2-gi:0] b_d;
      logic [WIDTH-2-gi:0] b_q;

      if (gi == 0) begin : g_in
        always_comb begin
          a_d = en ? a[WIDTH-1:1] : a_q;
          b_d = en ? b[WIDTH-1:1] : b_q;
        end
      end else begin : g_in
        always_comb begin
          a_d = en ? stage[gi-1].g_skew.a_q[WIDTH-1-gi:1] : a_q;
          b_d = en ? stage[gi-1].g_skew.b_q[WIDTH-1-gi:1] : b_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

`ifdef FPA_OUTPUT_REG_EN
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] s_q;
  logic             carry_d;
  logic             carry_q;

  always_comb begin
    s_d     = s_q;
    carry_d = carry_q;
    if (en) begin
      s_d     = stage[WIDTH-1].sum_q;
      carry_d = stage[WIDTH-1].carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      carry_q <= carry_d;
    end
  end

  assign s     = s_q;
  assign carry = carry_q;
`else
  assign s     = stage[WIDTH-1].sum_q;
  assign carry = stage[WIDTH-1].carry_q;
`endif

endmodule

// File: tb/tb_fully_pipelined_adder.sv
// Self-checking bench for fully_pipelined_adder (WIDTH=3): vector table, corner sequences, random run.
module tb_fully_pipelined_adder;
  localparam int W = 3;
`ifdef FPA_OUTPUT_REG_EN
  localparam int LAT = W;
`else
  localparam int LAT = W - 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic         c = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] s;
  logic         carry;

  always #5 clk = ~clk;

  fully_pipelined_adder #(.WIDTH(W)) dut (
    .s(s), .carry(carry), .a(a), .b(b), .c(c), .en(en), .clk(clk), .rst(rst)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: every enabled edge enqueues a+b+c; the value leaving the queue is what the output shows
  logic [W:0] model_q[$];
  logic [W:0] model_out = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         carry;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got s=%0d carry=%0d, expected s=%0d carry=%0d",
               name, got[W-1:0], got[W], exp[W-1:0], exp[W]);
    end
  endtask

  task automatic cycle(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input logic eni, input logic rsti);
    a = ai; b = bi; c = ci; en = eni; rst = rsti;
    @(posedge clk);
    #1;
    if (rsti) begin
      model_q.delete();
      repeat (LAT) model_q.push_back('0);
      model_out = '0;
    end else if (eni) begin
      model_q.push_back((W+1)'(ai) + (W+1)'(bi) + (W+1)'(ci));
      model_out = model_q.pop_front();
    end
    $display("t=%0t a=%0d b=%0d c=%0d en=%0d rst=%0d -> s=%0d carry=%0d",
             $time, ai, bi, ci, eni, rsti, s, carry);
    check("model", {carry, s}, model_out);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [W:0] b2b_exp[4];
  logic [W-1:0] b2b_a[4];
  logic [W-1:0] b2b_b[4];
  logic         b2b_c[4];
  logic [W:0]   held;
  bit           saw_bad;

  initial begin
    vecs[0] = '{a: 3'd0, b: 3'd2, c: 1'b0, s: 3'd2, carry: 1'b0};
    vecs[1] = '{a: 3'd1, b: 3'd1, c: 1'b1, s: 3'd3, carry: 1'b0};
    vecs[2] = '{a: 3'd2, b: 3'd3, c: 1'b0, s: 3'd5, carry: 1'b0};
    vecs[3] = '{a: 3'd7, b: 3'd7, c: 1'b1, s: 3'd7, carry: 1'b1};
    vecs[4] = '{a: 3'd4, b: 3'd4, c: 1'b0, s: 3'd0, carry: 1'b1};
    b2b_a = '{3'd0, 3'd1, 3'd2, 3'd7};
    b2b_b = '{3'd2, 3'd1, 3'd3, 3'd7};
    b2b_c = '{1'b0, 1'b1, 1'b0, 1'b1};
    b2b_exp = '{4'd2, 4'd3, 4'd5, 4'd15};

    // Reset state
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    check("reset_state", {carry, s}, '0);
    idle(LAT);

    // Single operations on an idle pipe
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, 1'b0);
      idle(LAT);
      check($sformatf("vec%0d", i), {carry, s}, {vecs[i].carry, vecs[i].s});
      idle(1);
    end

    // Back-to-back operands, results on consecutive cycles
    for (int k = 0; k < 4 + LAT; k++) begin
      if (k < 4) cycle(b2b_a[k], b2b_b[k], b2b_c[k], 1'b1, 1'b0);
      else       idle(1);
      if (k >= LAT) check($sformatf("b2b%0d", k - LAT), {carry, s}, b2b_exp[k - LAT]);
    end
    idle(LAT);

    // Stall: outputs frozen while en=0, result after LAT further enabled edges
    cycle(3'd2, 3'd3, 1'b0, 1'b1, 1'b0);
    held = '0;
    for (int k = 0; k < 3; k++) begin
      cycle(3'(k + 1), 3'd6, 1'b1, 1'b0, 1'b0);
      check("stall_hold", {carry, s}, held);
    end
    idle(LAT);
    check("stall_result", {carry, s}, 4'd5);
    idle(1);

    // Reset mid-operation discards in-flight 7+7+1
    cycle(3'd7, 3'd7, 1'b1, 1'b1, 1'b0);
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    check("mid_reset", {carry, s}, '0);
    saw_bad = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      idle(1);
      if ({carry, s} === 4'd15) saw_bad = 1'b1;
    end
    n_checks++;
    if (saw_bad) begin
      n_fail++;
      $display("FAIL reset_discard: got s=7 carry=1 after reset, required never");
    end

    // Randomized traffic with occasional stalls and resets
    for (int k = 0; k < 300; k++) begin
      cycle(3'($urandom), 3'($urandom), 1'($urandom),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
